// File: rtl/omsp_lpm_ctrl_if.sv
// Peripheral bus seen by the low-power-mode controller: word address, byte-enabled write, combinational read.
interface omsp_lpm_ctrl_if;
  logic [7:0]  per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;

  modport master (output per_addr, per_din, per_en, per_we, input  per_dout);
  modport slave  (input  per_addr, per_din, per_en, per_we, output per_dout);
endinterface

// File: rtl/omsp_lpm_ctrl.sv
// Low-power-mode sequencer: gates the CPU clock on a CPUOFF request, optionally waits for
// the LFXT oscillator to settle on wakeup, and counts the cycles spent asleep.
module omsp_lpm_ctrl #(
  parameter logic [8:0] LPMCTL = 9'h05A,
  parameter logic [8:0] LPMCNT = 9'h05C
) (
  input  logic          mclk,
  input  logic          por_reset,
  omsp_lpm_ctrl_if.slave per,
  input  logic          cpuoff_req,
  input  logic          scg1_req,
  input  logic          oscoff_req,
  input  logic          irq_pending,
  output logic          mclk_en,
  output logic          scg1_o,
  output logic          oscoff_o,
  output logic          wakeup_ack,
  output logic [2:0]    lpm_state
);

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    GATE_SM    = 3'd1,
    SLEEP      = 3'd2,
    OSC_SETTLE = 3'd3,
    RESUME     = 3'd4
  } state_t;

  localparam logic [7:0] CTL_IDX = LPMCTL[8:1];
  localparam logic [7:0] CNT_IDX = LPMCNT[8:1];

  state_t      state, state_nxt;
  logic        lpm_en;
  logic [7:0]  settle;
  logic [15:0] lpmcnt;
  logic [7:0]  settle_cnt;
  logic        cpuoff_q, scg1_l, osc_l;

  logic ctl_sel, cnt_sel, ctl_rd, cnt_rd, cnt_wr;
  logic cpuoff_rise;

  assign ctl_sel = per.per_en & (per.per_addr == CTL_IDX);
  assign cnt_sel = per.per_en & (per.per_addr == CNT_IDX);
  assign ctl_rd  = ctl_sel & (per.per_we == 2'b00);
  assign cnt_rd  = cnt_sel & (per.per_we == 2'b00);
  assign cnt_wr  = cnt_sel & (|per.per_we);

  assign per.per_dout = ({16{ctl_rd}} & {lpm_en, 7'b0, settle})
                      | ({16{cnt_rd}} & lpmcnt);

  always_ff @(posedge mclk or posedge por_reset)
    if (por_reset) begin
      lpm_en <= 1'b1;
      settle <= 8'h10;
    end else begin
      if (ctl_sel & per.per_we[0]) settle <= per.per_din[7:0];
      if (ctl_sel & per.per_we[1]) lpm_en <= per.per_din[15];
    end

  // Software clear takes priority over the sleep-time increment.
  always_ff @(posedge mclk or posedge por_reset)
    if (por_reset)                             lpmcnt <= 16'h0000;
    else if (cnt_wr)                           lpmcnt <= 16'h0000;
    else if (state == SLEEP && lpmcnt != 16'hFFFF) lpmcnt <= lpmcnt + 16'h0001;

  always_ff @(posedge mclk or posedge por_reset)
    if (por_reset) cpuoff_q <= 1'b0;
    else           cpuoff_q <= cpuoff_req;

  assign cpuoff_rise = cpuoff_req & ~cpuoff_q;

  always_ff @(posedge mclk or posedge por_reset)
    if (por_reset) begin
      scg1_l <= 1'b0;
      osc_l  <= 1'b0;
    end else if (state == RUN && state_nxt == GATE_SM) begin
      scg1_l <= scg1_req;
      osc_l  <= oscoff_req;
    end else if (state == RESUME) begin
      scg1_l <= 1'b0;
      osc_l  <= 1'b0;
    end

  // Loaded once on entry so LPMCTL writes during settling cannot stretch or cut it.
  always_ff @(posedge mclk or posedge por_reset)
    if (por_reset)                                  settle_cnt <= 8'h00;
    else if (state == SLEEP && state_nxt == OSC_SETTLE) settle_cnt <= settle;
    else if (state == OSC_SETTLE && settle_cnt != 8'h00) settle_cnt <= settle_cnt - 8'h01;

  always_ff @(posedge mclk or posedge por_reset)
    if (por_reset) state <= RUN;
    else           state <= state_nxt;

  always_comb begin
    state_nxt  = state;
    mclk_en    = 1'b1;
    scg1_o     = 1'b0;
    oscoff_o   = 1'b0;
    wakeup_ack = 1'b0;
    case (state)
      RUN:
        if (lpm_en & cpuoff_rise & ~irq_pending) state_nxt = GATE_SM;
      GATE_SM: begin
        scg1_o    = scg1_l;
        state_nxt = irq_pending ? RESUME : SLEEP;
      end
      SLEEP: begin
        mclk_en  = 1'b0;
        scg1_o   = scg1_l;
        oscoff_o = osc_l;
        if (irq_pending) state_nxt = osc_l ? OSC_SETTLE : RESUME;
      end
      OSC_SETTLE: begin
        mclk_en = 1'b0;
        scg1_o  = scg1_l;
        if (settle_cnt == 8'h00) state_nxt = RESUME;
      end
      RESUME: begin
        wakeup_ack = 1'b1;
        state_nxt  = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign lpm_state = state;

endmodule

// File: tb/tb_omsp_lpm_ctrl.sv
// Directed bench for omsp_lpm_ctrl: register access, sleep/wake sequencing, aborts, reset and saturation.
`timescale 1ns/1ps
module tb_omsp_lpm_ctrl;
  logic       mclk = 1'b0;
  logic       por_reset;
  logic       cpuoff_req, scg1_req, oscoff_req, irq_pending;
  logic       mclk_en, scg1_o, oscoff_o, wakeup_ack;
  logic [2:0] lpm_state;

  int checks = 0;
  int failures = 0;
  int wake_cnt = 0;
  int gated_cnt = 0;

  omsp_lpm_ctrl_if bus ();

  omsp_lpm_ctrl dut (
    .mclk(mclk), .por_reset(por_reset), .per(bus),
    .cpuoff_req(cpuoff_req), .scg1_req(scg1_req), .oscoff_req(oscoff_req),
    .irq_pending(irq_pending), .mclk_en(mclk_en), .scg1_o(scg1_o),
    .oscoff_o(oscoff_o), .wakeup_ack(wakeup_ack), .lpm_state(lpm_state)
  );

  always #5 mclk = ~mclk;

  always @(negedge mclk) begin
    if (wakeup_ack) wake_cnt++;
    if (!mclk_en)   gated_cnt++;
  end

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] we);
    @(negedge mclk);
    bus.per_addr = a; bus.per_din = d; bus.per_we = we; bus.per_en = 1'b1;
    @(negedge mclk);
    bus.per_en = 1'b0; bus.per_we = 2'b00;
  endtask

  task automatic rd(input logic [7:0] a, output logic [15:0] d);
    @(negedge mclk);
    bus.per_addr = a; bus.per_we = 2'b00; bus.per_en = 1'b1;
    #1 d = bus.per_dout;
    bus.per_en = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] d;
    por_reset = 1'b1;
    repeat (2) @(negedge mclk);
    checks++;
    if ({lpm_state, mclk_en, scg1_o, oscoff_o, wakeup_ack} !== 7'b000_1000) begin
      failures++; $display("FAIL reset_outputs: got %b exp %b", {lpm_state, mclk_en, scg1_o, oscoff_o, wakeup_ack}, 7'b000_1000);
    end
    checks++;
    if (bus.per_dout !== 16'h0000) begin failures++; $display("FAIL idle_dout: got %h exp 0000", bus.per_dout); end
    por_reset = 1'b0;
    rd(8'h2D, d); checks++;
    if (d !== 16'h8010) begin failures++; $display("FAIL reset_lpmctl: got %h exp 8010", d); end
    rd(8'h2E, d); checks++;
    if (d !== 16'h0000) begin failures++; $display("FAIL reset_lpmcnt: got %h exp 0000", d); end
  endtask

  task automatic test_reg_access;
    logic [15:0] d;
    wr(8'h2D, 16'hFFFF, 2'b11); rd(8'h2D, d); checks++;
    if (d !== 16'h80FF) begin failures++; $display("FAIL ctl_full_write: got %h exp 80FF", d); end
    wr(8'h2D, 16'h1234, 2'b01); rd(8'h2D, d); checks++;
    if (d !== 16'h8034) begin failures++; $display("FAIL ctl_low_byte: got %h exp 8034", d); end
    wr(8'h2D, 16'h00FF, 2'b10); rd(8'h2D, d); checks++;
    if (d !== 16'h0034) begin failures++; $display("FAIL ctl_high_byte: got %h exp 0034", d); end
    wr(8'h2D, 16'h8000, 2'b10); rd(8'h2D, d); checks++;
    if (d !== 16'h8034) begin failures++; $display("FAIL ctl_reenable: got %h exp 8034", d); end
  endtask

  task automatic test_sleep_no_osc;
    logic [15:0] d;
    int w0, g0, lat;
    logic en_prev, bad;
    wr(8'h2E, 16'h0000, 2'b01);
    cpuoff_req = 1'b1; scg1_req = 1'b1; oscoff_req = 1'b0;
    w0 = wake_cnt; g0 = gated_cnt;
    @(negedge mclk); checks++;
    if ({lpm_state, mclk_en, scg1_o} !== 5'b001_1_1) begin
      failures++; $display("FAIL gate_sm_cycle: got %b exp 00111", {lpm_state, mclk_en, scg1_o});
    end
    bad = 1'b0;
    repeat (10) begin
      @(negedge mclk);
      if (mclk_en !== 1'b0 || scg1_o !== 1'b1 || lpm_state !== 3'd2) bad = 1'b1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL sleep_outputs: got bad=%b exp 0", bad); end
    irq_pending = 1'b1;
    lat = 0; en_prev = 1'b0;
    while (lat < 40) begin
      @(posedge mclk); lat++;
      if (en_prev) break;
      @(negedge mclk); en_prev = mclk_en;
      irq_pending = 1'b0;
    end
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL wake_latency: got %0d exp 2", lat); end
    @(negedge mclk); checks++;
    if (lpm_state !== 3'd0) begin failures++; $display("FAIL back_to_run: got %0d exp 0", lpm_state); end
    checks++;
    if (gated_cnt - g0 !== 10) begin failures++; $display("FAIL gated_cycles: got %0d exp 10", gated_cnt - g0); end
    checks++;
    if (wake_cnt - w0 !== 1) begin failures++; $display("FAIL wake_pulses: got %0d exp 1", wake_cnt - w0); end
    rd(8'h2E, d); checks++;
    if (d !== 16'd10) begin failures++; $display("FAIL lpmcnt_10: got %0d exp 10", d); end
    cpuoff_req = 1'b0; scg1_req = 1'b0;
  endtask

  task automatic test_sleep_osc;
    int w0, lat;
    logic en_prev;
    wr(8'h2D, 16'h8005, 2'b11);
    @(negedge mclk);
    cpuoff_req = 1'b1; oscoff_req = 1'b1;
    w0 = wake_cnt;
    repeat (3) @(negedge mclk);
    checks++;
    if ({lpm_state, mclk_en, oscoff_o} !== 5'b010_0_1) begin
      failures++; $display("FAIL osc_sleep: got %b exp 01001", {lpm_state, mclk_en, oscoff_o});
    end
    irq_pending = 1'b1;
    lat = 0; en_prev = 1'b0;
    while (lat < 40) begin
      @(posedge mclk); lat++;
      if (en_prev) break;
      @(negedge mclk); en_prev = mclk_en;
      if (lat == 1) begin
        checks++;
        if ({lpm_state, oscoff_o} !== 4'b011_0) begin
          failures++; $display("FAIL osc_restart: got %b exp 0110", {lpm_state, oscoff_o});
        end
        irq_pending = 1'b0;
      end
    end
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL settle_latency: got %0d exp 8", lat); end
    @(negedge mclk); checks++;
    if (wake_cnt - w0 !== 1) begin failures++; $display("FAIL osc_wake_pulses: got %0d exp 1", wake_cnt - w0); end
    cpuoff_req = 1'b0; oscoff_req = 1'b0;
  endtask

  task automatic test_abort;
    int g0, w0;
    g0 = gated_cnt; w0 = wake_cnt;
    @(negedge mclk);
    cpuoff_req = 1'b1; irq_pending = 1'b1;
    @(negedge mclk); checks++;
    if (lpm_state !== 3'd0) begin failures++; $display("FAIL irq_with_rise: got %0d exp 0", lpm_state); end
    cpuoff_req = 1'b0; irq_pending = 1'b0;
    @(negedge mclk);
    cpuoff_req = 1'b1;
    @(negedge mclk); checks++;
    if (lpm_state !== 3'd1) begin failures++; $display("FAIL abort_gate: got %0d exp 1", lpm_state); end
    irq_pending = 1'b1;
    @(negedge mclk); checks++;
    if ({lpm_state, wakeup_ack, mclk_en} !== 5'b100_1_1) begin
      failures++; $display("FAIL abort_resume: got %b exp 10011", {lpm_state, wakeup_ack, mclk_en});
    end
    irq_pending = 1'b0;
    repeat (6) @(negedge mclk);
    checks++;
    if (lpm_state !== 3'd0 || wakeup_ack !== 1'b0) begin
      failures++; $display("FAIL no_reentry: got state %0d ack %b exp 0 0", lpm_state, wakeup_ack);
    end
    checks++;
    if (gated_cnt - g0 !== 0 || wake_cnt - w0 !== 1) begin
      failures++; $display("FAIL abort_counts: got gated %0d wake %0d exp 0 1", gated_cnt - g0, wake_cnt - w0);
    end
    cpuoff_req = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [15:0] d;
    int w0;
    wr(8'h2D, 16'h8014, 2'b11);
    cpuoff_req = 1'b1; oscoff_req = 1'b1;
    repeat (3) @(negedge mclk);
    irq_pending = 1'b1;
    @(negedge mclk); checks++;
    if ({lpm_state, oscoff_o, mclk_en} !== 5'b011_0_0) begin
      failures++; $display("FAIL enter_settle: got %b exp 01100", {lpm_state, oscoff_o, mclk_en});
    end
    w0 = wake_cnt;
    #2 por_reset = 1'b1;
    #1 checks++;
    if ({lpm_state, mclk_en, scg1_o, oscoff_o, wakeup_ack} !== 7'b000_1000) begin
      failures++; $display("FAIL mid_reset_outputs: got %b exp 0001000", {lpm_state, mclk_en, scg1_o, oscoff_o, wakeup_ack});
    end
    cpuoff_req = 1'b0; oscoff_req = 1'b0; irq_pending = 1'b0;
    rd(8'h2D, d); checks++;
    if (d !== 16'h8010) begin failures++; $display("FAIL mid_reset_lpmctl: got %h exp 8010", d); end
    @(negedge mclk) por_reset = 1'b0;
    repeat (3) @(negedge mclk);
    checks++;
    if (wake_cnt - w0 !== 0 || lpm_state !== 3'd0) begin
      failures++; $display("FAIL mid_reset_no_ack: got wake %0d state %0d exp 0 0", wake_cnt - w0, lpm_state);
    end
  endtask

  task automatic test_saturation;
    logic [15:0] d;
    @(negedge mclk) cpuoff_req = 1'b1;
    repeat (65545) @(posedge mclk);
    rd(8'h2E, d); checks++;
    if (d !== 16'hFFFF) begin failures++; $display("FAIL lpmcnt_saturate: got %h exp FFFF", d); end
    wr(8'h2D, 16'h0000, 2'b10);
    wr(8'h2E, 16'h0000, 2'b10);
    rd(8'h2E, d); checks++;
    if (d !== 16'h0001) begin failures++; $display("FAIL write_wins: got %h exp 0001", d); end
    checks++;
    if (lpm_state !== 3'd2) begin failures++; $display("FAIL lpm_en_no_abort: got %0d exp 2", lpm_state); end
    irq_pending = 1'b1;
    repeat (2) @(negedge mclk);
    irq_pending = 1'b0; cpuoff_req = 1'b0;
    checks++;
    if (lpm_state !== 3'd0 || mclk_en !== 1'b1) begin
      failures++; $display("FAIL sat_wake: got state %0d en %b exp 0 1", lpm_state, mclk_en);
    end
  endtask

  initial begin
    por_reset = 1'b1;
    cpuoff_req = 1'b0; scg1_req = 1'b0; oscoff_req = 1'b0; irq_pending = 1'b0;
    bus.per_addr = 8'h00; bus.per_din = 16'h0000; bus.per_en = 1'b0; bus.per_we = 2'b00;
    test_reset;
    test_reg_access;
    test_sleep_no_osc;
    test_sleep_osc;
    test_abort;
    test_reset_mid;
    test_saturation;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
